avalon_st_packet_source: RTL and testbench

//   Command-driven Avalon-ST packet generator: transmitter counterpart to the stream

---
 rtl/avalon_st_packet_source_if.sv | 38 +++
 rtl/avalon_st_packet_source.sv | 144 ++++++++++++++
 tb/tb_avalon_st_packet_source.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_st_packet_source_if.sv
// Avalon-ST packet source bus bundle.
// Carries the command channel into the source and the stream it emits.
//   cmd_valid/cmd_ready/cmd_length/cmd_empty/cmd_seed : command channel
//   stream_out_*                                      : Avalon-ST source, readyLatency 0
// Handshake: a command or beat moves on a rising clock edge where valid && ready.
// Once valid is high it stays high, and the payload stays stable, until that edge.
// master = the packet source, slave = whoever feeds commands and sinks the stream.
interface avalon_st_packet_source_if #(
    parameter int DATA_BYTES = 8,
    parameter int LEN_W      = 16
);
    localparam int EMPTY_W = $clog2(DATA_BYTES);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [LEN_W-1:0]        cmd_length;
    logic [EMPTY_W-1:0]      cmd_empty;
    logic [7:0]              cmd_seed;

    logic [DATA_BYTES*8-1:0] stream_out_data;
    logic [EMPTY_W-1:0]      stream_out_empty;
    logic                    stream_out_valid;
    logic                    stream_out_startofpacket;
    logic                    stream_out_endofpacket;
    logic                    stream_out_ready;

    modport master (
        input  cmd_valid, cmd_length, cmd_empty, cmd_seed, stream_out_ready,
        output cmd_ready, stream_out_data, stream_out_empty, stream_out_valid,
               stream_out_startofpacket, stream_out_endofpacket
    );

    modport slave (
        output cmd_valid, cmd_length, cmd_empty, cmd_seed, stream_out_ready,
        input  cmd_ready, stream_out_data, stream_out_empty, stream_out_valid,
               stream_out_startofpacket, stream_out_endofpacket
    );
endinterface

// File: rtl/avalon_st_packet_source.sv
// Command-driven Avalon-ST packet generator.
// Each accepted command with a nonzero length emits one packet of cmd_length beats;
// byte k of beat n is (seed + n*DATA_BYTES + k) mod 256, byte 0 in the MSB lane.
// On the eop beat the low cmd_empty bytes are driven to zero.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus (master)   : command channel in, Avalon-ST stream out
//   busy           : packet in progress
//   packet_count   : packets completed (wraps silently)
//   dbg_state_o    : current FSM state (0 = IDLE, 1 = SEND)
module avalon_st_packet_source #(
    parameter int DATA_BYTES = 8,
    parameter int LEN_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    avalon_st_packet_source_if.master   bus,
    output logic                        busy,
    output logic [31:0]                 packet_count,
    output logic                        dbg_state_o
);
    localparam int EMPTY_W = $clog2(DATA_BYTES);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                  state_q;
    logic [LEN_W-1:0]        n_q;
    logic [LEN_W-1:0]        len_q;
    logic [EMPTY_W-1:0]      empty_q;
    logic [7:0]              base_q;       // first byte value of the beat on the bus
    logic [DATA_BYTES*8-1:0] data_q;
    logic [EMPTY_W-1:0]      out_empty_q;
    logic                    valid_q;
    logic                    sop_q;
    logic                    eop_q;
    logic                    cmd_ready_q;
    logic                    busy_q;
    logic [31:0]             count_q;

    logic [LEN_W-1:0]        n_d;
    logic [7:0]              base_d;
    logic                    last_d;       // the beat after the current one is the eop beat
    logic                    first_last;   // the incoming command is a single-beat packet

    // Builds one beat from its first byte value; trailing empty bytes are zeroed on eop.
    function automatic logic [DATA_BYTES*8-1:0] beat_data(
        input logic [7:0]         base,
        input logic               eop,
        input logic [EMPTY_W-1:0] emp
    );
        logic [DATA_BYTES*8-1:0] d;
        logic [7:0]              b;
        d = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            b = base + 8'(k);
            if (eop && (k >= DATA_BYTES - int'(emp)))
                b = 8'h00;
            d[DATA_BYTES*8-1-8*k -: 8] = b;
        end
        return d;
    endfunction

    always_comb begin
        n_d        = n_q + LEN_W'(1);
        base_d     = base_q + 8'(DATA_BYTES);
        last_d     = (n_d == (len_q - LEN_W'(1)));
        first_last = (bus.cmd_length == LEN_W'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            len_q       <= '0;
            empty_q     <= '0;
            base_q      <= '0;
            data_q      <= '0;
            out_empty_q <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    // Zero-length commands are consumed without producing a beat.
                    if (bus.cmd_valid && cmd_ready_q && (bus.cmd_length != '0)) begin
                        state_q     <= SEND;
                        len_q       <= bus.cmd_length;
                        empty_q     <= bus.cmd_empty;
                        base_q      <= bus.cmd_seed;
                        n_q         <= '0;
                        data_q      <= beat_data(bus.cmd_seed, first_last, bus.cmd_empty);
                        out_empty_q <= first_last ? bus.cmd_empty : '0;
                        valid_q     <= 1'b1;
                        sop_q       <= 1'b1;
                        eop_q       <= first_last;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                SEND: begin
                    if (valid_q && bus.stream_out_ready) begin
                        if (eop_q) begin
                            // Ready rises with the return to IDLE, so the next command
                            // lands one cycle later and its first beat after that.
                            state_q     <= IDLE;
                            n_q         <= '0;
                            data_q      <= '0;
                            out_empty_q <= '0;
                            valid_q     <= 1'b0;
                            sop_q       <= 1'b0;
                            eop_q       <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            count_q     <= count_q + 32'd1;
                        end else begin
                            n_q         <= n_d;
                            base_q      <= base_d;
                            data_q      <= beat_data(base_d, last_d, empty_q);
                            out_empty_q <= last_d ? empty_q : '0;
                            sop_q       <= 1'b0;
                            eop_q       <= last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready                = cmd_ready_q;
    assign bus.stream_out_data          = data_q;
    assign bus.stream_out_empty         = out_empty_q;
    assign bus.stream_out_valid         = valid_q;
    assign bus.stream_out_startofpacket = sop_q;
    assign bus.stream_out_endofpacket   = eop_q;
    assign busy                         = busy_q;
    assign packet_count                 = count_q;
    assign dbg_state_o                  = state_q;
endmodule

// File: tb/tb_avalon_st_packet_source.sv
module tb_avalon_st_packet_source;
    localparam int DB = 8;
    localparam int LW = 16;
    localparam int BW = DB*8 + 3 + 2;   // {data, empty, sop, eop}

    logic        clk;
    logic        reset_n;
    logic        busy;
    logic [31:0] packet_count;
    logic        dbg_state;

    avalon_st_packet_source_if #(.DATA_BYTES(DB), .LEN_W(LW)) bus ();

    avalon_st_packet_source #(.DATA_BYTES(DB), .LEN_W(LW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .busy         (busy),
        .packet_count (packet_count),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [BW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_xfer   = 0;
    int            exp_pkts = 0;
    logic          held     = 1'b0;
    logic [BW-1:0] held_beat;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic logic [BW-1:0] cur_beat();
        return {bus.stream_out_data, bus.stream_out_empty,
                bus.stream_out_startofpacket, bus.stream_out_endofpacket};
    endfunction

    // Reference beat straight from the byte formula.
    function automatic logic [BW-1:0] model_beat(input int len, input int emp,
                                                 input int seed, input int n);
        logic [DB*8-1:0] d;
        logic            eop;
        int              v;
        d   = '0;
        eop = (n == len - 1);
        for (int k = 0; k < DB; k++) begin
            v = (seed + n*DB + k) % 256;
            if (eop && k >= DB - emp) v = 0;
            d[DB*8-1-8*k -: 8] = v[7:0];
        end
        return {d, (eop ? 3'(emp) : 3'd0), (n == 0), eop};
    endfunction

    // Sampled at the falling edge: checks stalls and scores transferring beats.
    task automatic monitor();
        logic [BW-1:0] cur;
        if (!reset_n) begin
            held = 1'b0;
            return;
        end
        cur = cur_beat();
        if (held) begin
            check("stall_valid", 128'(bus.stream_out_valid), 128'd1);
            check("stall_hold", 128'(cur), 128'(held_beat));
        end
        if (bus.stream_out_valid) begin
            if (bus.stream_out_ready) begin
                n_xfer++;
                held = 1'b0;
                if (exp_q.size() == 0) fail("unexpected_beat");
                else check("beat", 128'(cur), 128'(exp_q.pop_front()));
            end else begin
                held      = 1'b1;
                held_beat = cur;
            end
        end else begin
            held = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input int len, input int emp, input int seed, input logic push);
        int t;
        t = 0;
        while (!bus.cmd_ready && t < 200) begin
            step();
            t++;
        end
        if (!bus.cmd_ready) fail("cmd_ready_timeout");
        bus.cmd_valid  = 1'b1;
        bus.cmd_length = LW'(len);
        bus.cmd_empty  = 3'(emp);
        bus.cmd_seed   = 8'(seed);
        if (push)
            for (int n = 0; n < len; n++) exp_q.push_back(model_beat(len, emp, seed, n));
        step();
        // Scramble the command fields: they must be ignored after acceptance.
        bus.cmd_valid  = 1'b0;
        bus.cmd_length = LW'($urandom_range(0, 65535));
        bus.cmd_empty  = 3'($urandom_range(0, 7));
        bus.cmd_seed   = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input logic rand_ready);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 2000) begin
            bus.stream_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            t++;
        end
        if (exp_q.size() != 0 || busy) fail("packet_timeout");
        bus.stream_out_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 128'(bus.stream_out_valid), 128'd0);
        check({tag, "_beat"}, 128'(cur_beat()), 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_count"}, 128'(packet_count), 128'd0);
        check({tag, "_cmd_ready"}, 128'(bus.cmd_ready), 128'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   len;
        int   emp;
        int   seed;
        logic rand_ready;
        int   exp_beats;
    } vec_t;

    vec_t vecs[6];
    int   x0;

    initial begin
        vecs[0] = '{len: 2, emp: 0, seed: 8'hAA, rand_ready: 1'b0, exp_beats: 2};
        vecs[1] = '{len: 4, emp: 7, seed: 8'hF0, rand_ready: 1'b1, exp_beats: 4};
        vecs[2] = '{len: 1, emp: 3, seed: 8'h00, rand_ready: 1'b1, exp_beats: 1};
        vecs[3] = '{len: 9, emp: 1, seed: 8'h37, rand_ready: 1'b1, exp_beats: 9};
        vecs[4] = '{len: 0, emp: 0, seed: 8'h55, rand_ready: 1'b0, exp_beats: 0};
        vecs[5] = '{len: 3, emp: 5, seed: 8'hFE, rand_ready: 1'b1, exp_beats: 3};

        reset_n              = 1'b0;
        bus.cmd_valid        = 1'b0;
        bus.cmd_length       = '0;
        bus.cmd_empty        = '0;
        bus.cmd_seed         = '0;
        bus.stream_out_ready = 1'b1;

        // 1: reset values, cmd_ready one edge after release
        repeat (3) step();
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("pre_edge_cmd_ready", 128'(bus.cmd_ready), 128'd0);
        @(posedge clk);
        #1;
        check("post_release_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        check("post_release_count", 128'(packet_count), 128'd0);

        // 2: len=3 empty=2 seed=0x10, ready held high
        exp_q.push_back({64'h1011121314151617, 3'd0, 1'b1, 1'b0});
        exp_q.push_back({64'h18191A1B1C1D1E1F, 3'd0, 1'b0, 1'b0});
        exp_q.push_back({64'h2021222324250000, 3'd2, 1'b0, 1'b1});
        x0 = n_xfer;
        send_cmd(3, 2, 8'h10, 1'b0);
        check("latency1_valid", 128'(bus.stream_out_valid), 128'd1);
        wait_done(1'b0);
        exp_pkts++;
        check("t2_beats", 128'(n_xfer - x0), 128'd3);
        check("t2_count", 128'(packet_count), 128'(exp_pkts));

        // 3: same command under the stall pattern 0,1,0,0,1,1
        begin
            logic pat[6];
            pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            exp_q.push_back({64'h1011121314151617, 3'd0, 1'b1, 1'b0});
            exp_q.push_back({64'h18191A1B1C1D1E1F, 3'd0, 1'b0, 1'b0});
            exp_q.push_back({64'h2021222324250000, 3'd2, 1'b0, 1'b1});
            x0 = n_xfer;
            bus.stream_out_ready = 1'b0;
            send_cmd(3, 2, 8'h10, 1'b0);
            for (int i = 0; i < 6; i++) begin
                bus.stream_out_ready = pat[i];
                step();
            end
            bus.stream_out_ready = 1'b1;
            exp_pkts++;
            check("t3_beats", 128'(n_xfer - x0), 128'd3);
            check("t3_valid_low", 128'(bus.stream_out_valid), 128'd0);
            check("t3_count", 128'(packet_count), 128'(exp_pkts));
        end

        // 4: single beat with byte wrap
        exp_q.push_back({64'hFCFDFEFF00010203, 3'd0, 1'b1, 1'b1});
        send_cmd(1, 0, 8'hFC, 1'b0);
        wait_done(1'b0);
        exp_pkts++;
        check("t4_count", 128'(packet_count), 128'(exp_pkts));

        // 5: zero-length command is swallowed
        send_cmd(0, 0, 8'h33, 1'b1);
        check("t5_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        check("t5_valid", 128'(bus.stream_out_valid), 128'd0);
        step();
        check("t5_valid_later", 128'(bus.stream_out_valid), 128'd0);
        check("t5_count", 128'(packet_count), 128'(exp_pkts));

        // table-driven vectors
        for (int v = 0; v < 6; v++) begin
            x0 = n_xfer;
            send_cmd(vecs[v].len, vecs[v].emp, vecs[v].seed, 1'b1);
            wait_done(vecs[v].rand_ready);
            if (vecs[v].len != 0) exp_pkts++;
            check($sformatf("vec%0d_beats", v), 128'(n_xfer - x0), 128'(vecs[v].exp_beats));
            check($sformatf("vec%0d_count", v), 128'(packet_count), 128'(exp_pkts));
            check($sformatf("vec%0d_busy", v), 128'(busy), 128'd0);
        end

        // 6: reset while beat 2 of a 5-beat packet is on the bus
        send_cmd(5, 0, 8'h40, 1'b1);
        step();
        check("t6_mid_packet", 128'(bus.stream_out_valid), 128'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        exp_q.delete();
        exp_pkts = 0;
        repeat (2) step();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        x0 = n_xfer;
        send_cmd(2, 0, 8'h00, 1'b1);
        wait_done(1'b0);
        exp_pkts++;
        check("t6_beats", 128'(n_xfer - x0), 128'd2);
        check("t6_count", 128'(packet_count), 128'(exp_pkts));

        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
